// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: tracks resident process slots, times the running
// slice and sequences the save/select/restore context-switch handshake with the CPU.
module process_scheduler #(
    parameter int NPROC     = 4,
    parameter int PID_W     = 2,
    parameter int QUANTUM   = 256,
    parameter int PART_SIZE = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_proc_create,
    input  logic [PID_W-1:0] i_create_id,
    input  logic             i_proc_exit,
    input  logic             i_ctx_saved,
    input  logic             i_ctx_restored,
    output logic             o_interruptionProcess,
    output logic             o_cpu_stall,
    output logic [PID_W-1:0] o_cur_pid,
    output logic [31:0]      o_base_addr,
    output logic [NPROC-1:0] o_ready_mask,
    output logic             o_idle
);

    localparam int CNT_W = $clog2(QUANTUM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RESTORE,
        S_RUN,
        S_SAVE
    } state_t;

    state_t             r_state;
    logic [NPROC-1:0]   r_ready_mask;
    logic [PID_W-1:0]   r_cur_pid;
    logic [31:0]        r_base_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_intr;
    logic               r_stall;
    logic               r_idle;

    state_t             w_state_nxt;
    logic [NPROC-1:0]   w_mask_nxt;
    logic               w_found;
    logic [PID_W-1:0]   w_sel;
    logic [PID_W-1:0]   w_idx;

    // Walk offsets from NPROC down to 1 so the nearest ready slot after cur_pid wins;
    // offset NPROC wraps to cur_pid itself and is therefore the last resort.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_cur_pid;
        w_idx   = r_cur_pid;
        for (int k = NPROC; k >= 1; k--) begin
            w_idx = r_cur_pid + PID_W'(k);
            if (r_ready_mask[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Exit clears before create sets, so a same-slot create/exit leaves the slot ready.
    always_comb begin
        w_mask_nxt = r_ready_mask;
        if (r_state == S_RUN && i_proc_exit) begin
            w_mask_nxt[r_cur_pid] = 1'b0;
        end
        if (i_proc_create) begin
            w_mask_nxt[i_create_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_ready_mask != '0 || i_proc_create) begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_state_nxt = w_found ? S_RESTORE : S_IDLE;
            end
            S_RESTORE: begin
                if (i_ctx_restored) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (i_proc_exit) begin
                    w_state_nxt = S_SELECT;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_SAVE;
                end
            end
            S_SAVE: begin
                if (i_ctx_saved) begin
                    w_state_nxt = S_SELECT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ready_mask <= '0;
            r_cur_pid    <= '0;
            r_base_addr  <= '0;
            r_cnt        <= CNT_W'(QUANTUM);
            r_intr       <= 1'b0;
            r_stall      <= 1'b1;
            r_idle       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ready_mask <= w_mask_nxt;
            r_intr       <= (r_state == S_SELECT) && w_found;
            r_stall      <= (w_state_nxt != S_RUN);
            r_idle       <= (w_state_nxt == S_IDLE);

            if (r_state == S_SELECT && w_found) begin
                r_cur_pid   <= w_sel;
                r_base_addr <= 32'(w_sel) * 32'(PART_SIZE);
            end

            // The slice counter is only ever reloaded on RESTORE->RUN and saturates at zero.
            if (r_state == S_RESTORE && i_ctx_restored) begin
                r_cnt <= CNT_W'(QUANTUM);
            end else if (r_state == S_RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_interruptionProcess = r_intr;
    assign o_cpu_stall           = r_stall;
    assign o_cur_pid             = r_cur_pid;
    assign o_base_addr           = r_base_addr;
    assign o_ready_mask          = r_ready_mask;
    assign o_idle                = r_idle;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: a vector table, directed context-switch sequences and a
// randomized run, all checked against a phase-level reference model.
module tb_process_scheduler;

    localparam int NPROC     = 4;
    localparam int PID_W     = 2;
    localparam int QUANTUM   = 256;
    localparam int PART_SIZE = 1024;

    localparam int P_IDLE = 0;
    localparam int P_SEL  = 1;
    localparam int P_RES  = 2;
    localparam int P_RUN  = 3;
    localparam int P_SAVE = 4;

    logic             clk;
    logic             rst_n;
    logic             i_proc_create;
    logic [PID_W-1:0] i_create_id;
    logic             i_proc_exit;
    logic             i_ctx_saved;
    logic             i_ctx_restored;
    logic             o_interruptionProcess;
    logic             o_cpu_stall;
    logic [PID_W-1:0] o_cur_pid;
    logic [31:0]      o_base_addr;
    logic [NPROC-1:0] o_ready_mask;
    logic             o_idle;

    int n_checks;
    int n_fail;

    int m_phase;
    bit m_ready[NPROC];
    int m_cur;
    int m_used;
    bit m_intr;

    process_scheduler #(
        .NPROC(NPROC), .PID_W(PID_W), .QUANTUM(QUANTUM), .PART_SIZE(PART_SIZE)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_proc_create        (i_proc_create),
        .i_create_id          (i_create_id),
        .i_proc_exit          (i_proc_exit),
        .i_ctx_saved          (i_ctx_saved),
        .i_ctx_restored       (i_ctx_restored),
        .o_interruptionProcess(o_interruptionProcess),
        .o_cpu_stall          (o_cpu_stall),
        .o_cur_pid            (o_cur_pid),
        .o_base_addr          (o_base_addr),
        .o_ready_mask         (o_ready_mask),
        .o_idle               (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cur   = 0;
        m_used  = 0;
        m_intr  = 0;
        for (int i = 0; i < NPROC; i++) m_ready[i] = 0;
    endtask

    function automatic logic [NPROC-1:0] model_mask();
        logic [NPROC-1:0] m;
        for (int i = 0; i < NPROC; i++) m[i] = m_ready[i];
        return m;
    endfunction

    // One clock of scheduler behaviour, expressed as phases, a ready list and a used-cycle tally.
    task automatic model_advance(input bit cr, input int cid, input bit ex, input bit sv, input bit rs);
        int  nph;
        bit  found;
        int  pick;
        nph    = m_phase;
        found  = 0;
        pick   = 0;
        m_intr = 0;
        case (m_phase)
            P_IDLE: if (model_mask() != 0 || cr) nph = P_SEL;
            P_SEL: begin
                for (int k = 1; k <= NPROC; k++) begin
                    if (!found && m_ready[(m_cur + k) % NPROC]) begin
                        found = 1;
                        pick  = (m_cur + k) % NPROC;
                    end
                end
                if (found) begin
                    nph    = P_RES;
                    m_cur  = pick;
                    m_intr = 1;
                end else begin
                    nph = P_IDLE;
                end
            end
            P_RES: if (rs) begin
                nph    = P_RUN;
                m_used = 0;
            end
            P_RUN: begin
                m_used++;
                if (ex) begin
                    m_ready[m_cur] = 0;
                    nph = P_SEL;
                end else if (m_used == QUANTUM) begin
                    nph = P_SAVE;
                end
            end
            P_SAVE: if (sv) nph = P_SEL;
            default: nph = P_IDLE;
        endcase
        if (cr) m_ready[cid] = 1;
        m_phase = nph;
    endtask

    task automatic compare_model(input string name);
        logic [63:0] act;
        logic [63:0] exp;
        act = {o_interruptionProcess, o_cpu_stall, o_idle, 6'(o_cur_pid), o_base_addr, 8'(o_ready_mask)};
        exp = {m_intr, m_phase != P_RUN, m_phase == P_IDLE, 6'(m_cur),
               32'(m_cur * PART_SIZE), 8'(model_mask())};
        chk(name, act, exp);
    endtask

    task automatic step(input bit cr, input int cid, input bit ex, input bit sv, input bit rs);
        i_proc_create  = cr;
        i_create_id    = PID_W'(cid);
        i_proc_exit    = ex;
        i_ctx_saved    = sv;
        i_ctx_restored = rs;
        @(posedge clk);
        #1;
        model_advance(cr, cid, ex, sv, rs);
        compare_model("model");
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic run_until_stall(output int n);
        n = 0;
        while (!o_cpu_stall && n < 400) begin
            n++;
            idle_step();
        end
    endtask

    task automatic do_reset();
        i_proc_create  = 0;
        i_create_id    = '0;
        i_proc_exit    = 0;
        i_ctx_saved    = 0;
        i_ctx_restored = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
    endtask

    typedef struct {
        bit           cr;
        bit [1:0]     cid;
        bit           ex;
        bit           sv;
        bit           rs;
        bit           e_intr;
        bit           e_stall;
        bit           e_idle;
        bit [1:0]     e_cur;
        bit [3:0]     e_mask;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        model_reset();

        //            cr cid ex sv rs  intr stall idle cur mask
        tbl[0]  = '{1, 2, 0, 0, 0,  0, 1, 0, 0, 4'b0100};
        tbl[1]  = '{0, 0, 0, 0, 0,  1, 1, 0, 2, 4'b0100};
        tbl[2]  = '{0, 0, 0, 0, 0,  0, 1, 0, 2, 4'b0100};
        tbl[3]  = '{0, 0, 0, 0, 1,  0, 0, 0, 2, 4'b0100};
        tbl[4]  = '{1, 2, 0, 0, 0,  0, 0, 0, 2, 4'b0100};
        tbl[5]  = '{1, 2, 1, 0, 0,  0, 1, 0, 2, 4'b0100};
        tbl[6]  = '{0, 0, 0, 0, 0,  1, 1, 0, 2, 4'b0100};
        tbl[7]  = '{0, 0, 0, 0, 1,  0, 0, 0, 2, 4'b0100};
        tbl[8]  = '{0, 0, 1, 0, 0,  0, 1, 0, 2, 4'b0000};
        tbl[9]  = '{0, 0, 0, 1, 0,  0, 1, 1, 2, 4'b0000};
        tbl[10] = '{0, 0, 0, 0, 1,  0, 1, 1, 2, 4'b0000};
        tbl[11] = '{1, 0, 0, 0, 0,  0, 1, 0, 2, 4'b0001};
        tbl[12] = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0001};

        do_reset();
        chk("reset_outputs",
            {o_interruptionProcess, o_cpu_stall, o_idle, o_cur_pid, o_base_addr, o_ready_mask},
            {1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 4'd0});

        for (int r = 0; r < 13; r++) begin
            step(tbl[r].cr, int'(tbl[r].cid), tbl[r].ex, tbl[r].sv, tbl[r].rs);
            chk($sformatf("table_row%0d", r),
                {o_interruptionProcess, o_cpu_stall, o_idle, o_cur_pid, o_base_addr, o_ready_mask},
                {tbl[r].e_intr, tbl[r].e_stall, tbl[r].e_idle, tbl[r].e_cur,
                 32'(tbl[r].e_cur) * 32'(PART_SIZE), tbl[r].e_mask});
        end

        // Slots 0,1,3 resident, running slot 0: full slices and round-robin order 0->1->3->0.
        step(1, 1, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("mask_013", 64'(o_ready_mask), 64'(4'b1011));
        run_until_stall(n);
        chk("slice_len_0", 64'(n), 64'(QUANTUM));
        chk("save_hold", {o_cpu_stall, o_idle, o_interruptionProcess, o_cur_pid}, {1'b1, 1'b0, 1'b0, 2'd0});
        repeat (3) idle_step();
        chk("save_waits", 64'(o_cur_pid), 64'(0));
        step(0, 0, 0, 1, 0);
        idle_step();
        chk("switch_to_1", {o_interruptionProcess, o_cur_pid, o_base_addr}, {1'b1, 2'd1, 32'h400});
        step(0, 0, 0, 0, 1);
        run_until_stall(n);
        chk("slice_len_1", 64'(n), 64'(QUANTUM));
        step(0, 0, 0, 1, 0);
        idle_step();
        chk("switch_to_3", {o_cur_pid, o_base_addr}, {2'd3, 32'hC00});
        step(0, 0, 0, 0, 1);
        run_until_stall(n);
        step(0, 0, 0, 1, 0);
        idle_step();
        chk("wrap_to_0", {o_cur_pid, o_base_addr}, {2'd0, 32'h0});

        // Exits: 0 leaves, then 1 leaves with only 3 left; no SAVE on the exit path.
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        idle_step();
        chk("after_exit0", {o_cur_pid, o_ready_mask}, {2'd1, 4'b1010});
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("exit1_mask", {o_ready_mask, o_cpu_stall, o_interruptionProcess}, {4'b1000, 1'b1, 1'b0});
        idle_step();
        chk("exit1_next", {o_interruptionProcess, o_cur_pid}, {1'b1, 2'd3});

        // Exit on the last cycle of the slice wins over expiry; with nothing left, go idle.
        step(0, 0, 0, 0, 1);
        repeat (QUANTUM - 1) idle_step();
        chk("before_last_cycle", 64'(o_cpu_stall), 64'(0));
        step(0, 0, 1, 0, 0);
        idle_step();
        chk("exit_at_expiry_idle", {o_idle, o_cpu_stall, o_ready_mask}, {1'b1, 1'b1, 4'b0000});
        step(1, 0, 0, 0, 0);
        idle_step();
        chk("recreate_0", {o_interruptionProcess, o_cur_pid}, {1'b1, 2'd0});

        // Asynchronous reset while waiting in SAVE, then a stale ctx_saved.
        step(0, 0, 0, 0, 1);
        run_until_stall(n);
        chk("slice_len_reset", 64'(n), 64'(QUANTUM));
        #2 rst_n = 0;
        #1;
        chk("async_reset",
            {o_interruptionProcess, o_cpu_stall, o_idle, o_cur_pid, o_base_addr, o_ready_mask},
            {1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 4'd0});
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("stale_ack_idle", {o_idle, o_cpu_stall}, {1'b1, 1'b1});

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 19) == 0, int'($urandom_range(0, NPROC - 1)),
                 $urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
